bnn_seq_ctrl: RTL and testbench

Parametrised instruction sequencer for the BNN accelerator. It fetches 16-bit instructions from the instruction SRAM and decodes them into the 20-bit BNN-core control word and the data-SRAM address/enable signals. Over the single-issue controller it adds:
- start/done handshake;
- explicit fetch pipeline with branch flush;
- hardware loop stack with an error flag;
- parametrised address, register and loop widths.

It sits between the instruction SRAM, the data SRAM and bnn_core.

---
 rtl/bnn_ctrl_pkg.sv | 58 +++++
 rtl/bnn_loop_stack.sv | 76 +++++++
 rtl/bnn_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_bnn_seq_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_ctrl_pkg.sv
// rtl/bnn_ctrl_pkg.sv - shared opcodes, core_ctrl bit map and FSM states for the BNN sequencer
//
// Contents:
//   OP_*        5-bit instruction opcodes (inst[15:11])
//   *_BIT       bit positions inside the 20-bit core_ctrl word
//   state_t     sequencer FSM states
//   ctrl_onehot helper building a core_ctrl word with a single bit set
package bnn_ctrl_pkg;

  localparam int CTRL_W = 20;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LDL   = 5'b00001;
  localparam logic [4:0] OP_LDH   = 5'b00010;
  localparam logic [4:0] OP_LOAD  = 5'b00011;
  localparam logic [4:0] OP_ADDI  = 5'b00100;
  localparam logic [4:0] OP_CMP   = 5'b00101;
  localparam logic [4:0] OP_JUMP  = 5'b00110;
  localparam logic [4:0] OP_EMPT  = 5'b00111;
  localparam logic [4:0] OP_BPUE  = 5'b01000;
  localparam logic [4:0] OP_BPUC  = 5'b01001;
  localparam logic [4:0] OP_OUT   = 5'b01010;
  localparam logic [4:0] OP_STORE = 5'b01011;
  localparam logic [4:0] OP_SHIFT = 5'b01100;
  localparam logic [4:0] OP_MOV   = 5'b01101;
  localparam logic [4:0] OP_LDLH  = 5'b01110;
  localparam logic [4:0] OP_LDHH  = 5'b01111;
  localparam logic [4:0] OP_LOOP  = 5'b10000;
  localparam logic [4:0] OP_ENDL  = 5'b10001;
  localparam logic [4:0] OP_HALT  = 5'b10010;

  localparam logic [4:0] EMPT_BIT   = 5'd0;
  localparam logic [4:0] BPUE_BIT   = 5'd1;
  localparam logic [4:0] WGT_EN_BIT = 5'd7;
  localparam logic [4:0] IMG_EN_BIT = 5'd8;
  localparam logic [4:0] BPUC_BIT   = 5'd9;
  localparam logic [4:0] OUT_BIT    = 5'd10;
  localparam logic [4:0] BIAS_BIT   = 5'd11;
  localparam logic [4:0] CFG_BIT    = 5'd12;
  localparam logic [4:0] STORE_BIT  = 5'd14;
  localparam logic [4:0] SHIFT_BIT  = 5'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

  function automatic logic [CTRL_W-1:0] ctrl_onehot(input logic [4:0] idx);
    logic [CTRL_W-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bnn_loop_stack.sv
// rtl/bnn_loop_stack.sv - LIFO of hardware-loop frames {start address, remaining count}
//
// Ports:
//   clk, rst          clock, synchronous active-low reset (empties the stack)
//   clr               synchronous clear (empties the stack)
//   push              push {push_start, push_count}; ignored when full
//   pop               drop the top frame; ignored when empty
//   dec_top           decrement the top frame's count; ignored when empty
//   top_start/count   contents of the top frame (undefined while empty)
//   full, empty       occupancy flags
// Priority when several requests coincide: clr > push > pop > dec_top.
module bnn_loop_stack #(
  parameter int DEPTH = 4,
  parameter int AW    = 11,
  parameter int CW    = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic          dec_top,
  input  logic [AW-1:0] push_start,
  input  logic [CW-1:0] push_count,
  output logic [AW-1:0] top_start,
  output logic [CW-1:0] top_count,
  output logic          full,
  output logic          empty
);

  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SLOTS = 1 << IDX_W;

  logic [SP_W-1:0]  sp;
  logic [AW-1:0]    start_mem [SLOTS];
  logic [CW-1:0]    count_mem [SLOTS];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             do_push;
  logic             do_pop;
  logic             do_dec;

  assign full    = (sp == SP_W'(DEPTH));
  assign empty   = (sp == '0);
  assign wr_idx  = IDX_W'(sp);
  assign top_idx = IDX_W'(sp - 1'b1);

  assign top_start = start_mem[top_idx];
  assign top_count = count_mem[top_idx];

  assign do_push = rst && !clr && push && !full;
  assign do_pop  = rst && !clr && !push && pop && !empty;
  assign do_dec  = rst && !clr && !push && !pop && dec_top && !empty;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + 1'b1;
    end else if (do_pop) begin
      sp <= sp - 1'b1;
    end
  end

  // Frame storage needs no reset: entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      start_mem[wr_idx] <= push_start;
      count_mem[wr_idx] <= push_count;
    end else if (do_dec) begin
      count_mem[top_idx] <= top_count - 1'b1;
    end
  end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// rtl/bnn_seq_ctrl.sv - instruction sequencer driving bnn_core control and data SRAM
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start               pulse; (re)starts execution at address 0 from IDLE/DONE
//   pause               freezes pc, registers and loop stack while RUN/FETCH/FLUSH
//   inst_rdata          instruction SRAM Q (1-cycle latency, holds while inst_cen high)
//   inst_addr/cen/wen   instruction SRAM fetch port (read only)
//   data_addr/cen/wen   data SRAM port, registered
//   core_ctrl           20-bit bnn_core control word, registered
//   busy, done          FSM status; loop_err sticky loop-stack fault until next start
module bnn_seq_ctrl
  import bnn_ctrl_pkg::*;
#(
  parameter int IADDR_W    = 11,
  parameter int DADDR_W    = 14,
  parameter int LOOP_DEPTH = 4,
  parameter int CNT_W      = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic [15:0]        inst_rdata,
  output logic [IADDR_W-1:0] inst_addr,
  output logic               inst_cen,
  output logic               inst_wen,
  output logic [DADDR_W-1:0] data_addr,
  output logic               data_cen,
  output logic               data_wen,
  output logic [CTRL_W-1:0]  core_ctrl,
  output logic               busy,
  output logic               done,
  output logic               loop_err
);

  state_t             state, state_nx;
  logic [IADDR_W-1:0] pc, pc_nx;
  logic               iv, iv_nx;
  logic               err_nx;
  logic [15:0]        regs [16];

  logic               reg_we;
  logic [3:0]         reg_wa;
  logic [15:0]        reg_wd;

  logic [CTRL_W-1:0]  ctrl_nx;
  logic               dcen_nx;
  logic               dwen_nx;
  logic [DADDR_W-1:0] daddr_nx;
  logic               fetch;

  logic               stk_push, stk_pop, stk_dec, stk_clr;
  logic [IADDR_W-1:0] stk_top_start;
  logic [CNT_W-1:0]   stk_top_count;
  logic [CNT_W-1:0]   loop_cnt;
  logic               stk_full, stk_empty;

  logic [4:0]         opcode;
  logic [IADDR_W-1:0] pc_exec;
  logic [IADDR_W-1:0] jump_tgt;
  logic [3:0]         lo_idx, hi_idx, ar_idx, mv_src;

  // While RUN, pc already points one past the instruction sitting in inst_rdata.
  assign opcode   = inst_rdata[15:11];
  assign pc_exec  = pc - 1'b1;
  assign jump_tgt = pc_exec - IADDR_W'(inst_rdata[10:0]);
  assign lo_idx   = {1'b0, inst_rdata[10:8]};
  assign hi_idx   = {1'b1, inst_rdata[10:8]};
  assign ar_idx   = inst_rdata[10:7];
  assign mv_src   = {1'b0, inst_rdata[7:5]};
  assign loop_cnt = (inst_rdata[CNT_W-1:0] == '0) ? CNT_W'(1) : inst_rdata[CNT_W-1:0];

  // Fetch port is combinational so that pause stops the SRAM the same cycle,
  // keeping the instruction under execution on Q until release.
  assign inst_addr = pc;
  assign inst_cen  = !fetch;
  assign inst_wen  = 1'b1;

  assign busy = (state == ST_FETCH) || (state == ST_RUN) || (state == ST_FLUSH);
  assign done = (state == ST_DONE);

  bnn_loop_stack #(
    .DEPTH (LOOP_DEPTH),
    .AW    (IADDR_W),
    .CW    (CNT_W)
  ) u_stack (
    .clk        (clk),
    .rst        (rst),
    .clr        (stk_clr),
    .push       (stk_push),
    .pop        (stk_pop),
    .dec_top    (stk_dec),
    .push_start (pc),
    .push_count (loop_cnt),
    .top_start  (stk_top_start),
    .top_count  (stk_top_count),
    .full       (stk_full),
    .empty      (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= '0;
      iv        <= 1'b0;
      loop_err  <= 1'b0;
      core_ctrl <= '0;
      data_cen  <= 1'b1;
      data_wen  <= 1'b1;
      data_addr <= '0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      iv        <= iv_nx;
      loop_err  <= err_nx;
      core_ctrl <= ctrl_nx;
      data_cen  <= dcen_nx;
      data_wen  <= dwen_nx;
      data_addr <= daddr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[reg_wa] <= reg_wd;
    end
  end

  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    iv_nx    = iv;
    err_nx   = loop_err;
    fetch    = 1'b0;
    reg_we   = 1'b0;
    reg_wa   = '0;
    reg_wd   = '0;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_dec  = 1'b0;
    stk_clr  = 1'b0;
    ctrl_nx  = '0;
    dcen_nx  = 1'b1;
    dwen_nx  = 1'b1;
    daddr_nx = data_addr;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nx = ST_FETCH;
          pc_nx    = '0;
          iv_nx    = 1'b0;
          err_nx   = 1'b0;
          stk_clr  = 1'b1;
        end
      end

      ST_FETCH, ST_FLUSH: begin
        if (!pause) begin
          fetch    = 1'b1;
          pc_nx    = pc + 1'b1;
          iv_nx    = 1'b1;
          state_nx = ST_RUN;
        end
      end

      ST_RUN: begin
        if (!pause) begin
          fetch = 1'b1;
          pc_nx = pc + 1'b1;
          iv_nx = 1'b1;
          if (iv) begin
            case (opcode)
              OP_LDL: begin
                reg_we = 1'b1;
                reg_wa = lo_idx;
                reg_wd = {regs[lo_idx][15:8], inst_rdata[7:0]};
              end
              OP_LDH: begin
                reg_we = 1'b1;
                reg_wa = lo_idx;
                reg_wd = {inst_rdata[7:0], regs[lo_idx][7:0]};
              end
              OP_LDLH: begin
                reg_we = 1'b1;
                reg_wa = hi_idx;
                reg_wd = {regs[hi_idx][15:8], inst_rdata[7:0]};
              end
              OP_LDHH: begin
                reg_we = 1'b1;
                reg_wa = hi_idx;
                reg_wd = {inst_rdata[7:0], regs[hi_idx][7:0]};
              end
              OP_ADDI: begin
                reg_we = 1'b1;
                reg_wa = ar_idx;
                reg_wd = regs[ar_idx] + {{9{inst_rdata[6]}}, inst_rdata[6:0]};
              end
              OP_CMP: begin
                reg_we = 1'b1;
                reg_wa = 4'd2;
                reg_wd = {15'd0, (regs[ar_idx] < {9'd0, inst_rdata[6:0]})};
              end
              OP_MOV: begin
                reg_we = 1'b1;
                reg_wa = lo_idx;
                reg_wd = regs[mv_src];
              end
              OP_JUMP: begin
                if (regs[2] != 16'd0) begin
                  pc_nx    = jump_tgt;
                  iv_nx    = 1'b0;
                  state_nx = ST_FLUSH;
                end
              end
              OP_LOAD: begin
                dcen_nx  = 1'b0;
                dwen_nx  = 1'b1;
                daddr_nx = regs[0][DADDR_W-1:0];
                reg_we   = 1'b1;
                reg_wa   = 4'd0;
                reg_wd   = inst_rdata[0] ? regs[0] + 16'd1 : regs[0] - 16'd1;
                case (inst_rdata[10:9])
                  2'd0:    ctrl_nx = ctrl_onehot(WGT_EN_BIT);
                  2'd1:    ctrl_nx = ctrl_onehot(BIAS_BIT);
                  2'd2:    ctrl_nx = ctrl_onehot(IMG_EN_BIT);
                  default: ctrl_nx = ctrl_onehot(CFG_BIT);
                endcase
              end
              OP_STORE: begin
                dcen_nx  = 1'b0;
                dwen_nx  = 1'b0;
                daddr_nx = regs[1][DADDR_W-1:0];
                ctrl_nx  = ctrl_onehot(STORE_BIT);
                reg_we   = 1'b1;
                reg_wa   = 4'd1;
                reg_wd   = inst_rdata[9] ? regs[1] + 16'd1 : regs[1] - 16'd1;
              end
              OP_EMPT:  ctrl_nx = ctrl_onehot(EMPT_BIT);
              OP_BPUE:  ctrl_nx = ctrl_onehot(BPUE_BIT);
              OP_BPUC:  ctrl_nx = ctrl_onehot(BPUC_BIT);
              OP_OUT:   ctrl_nx = ctrl_onehot(OUT_BIT);
              OP_SHIFT: ctrl_nx = ctrl_onehot(SHIFT_BIT);
              OP_LOOP: begin
                if (stk_full) begin
                  err_nx   = 1'b1;
                  state_nx = ST_DONE;
                end else begin
                  stk_push = 1'b1;
                end
              end
              OP_ENDL: begin
                if (stk_empty) begin
                  err_nx   = 1'b1;
                  state_nx = ST_DONE;
                end else if (stk_top_count > CNT_W'(1)) begin
                  stk_dec  = 1'b1;
                  pc_nx    = stk_top_start;
                  iv_nx    = 1'b0;
                  state_nx = ST_FLUSH;
                end else begin
                  stk_pop = 1'b1;
                end
              end
              OP_HALT: state_nx = ST_DONE;
              default: ;
            endcase
          end
        end
      end

      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// tb/tb_bnn_seq_ctrl.sv - directed self-checking bench for bnn_seq_ctrl
module tb_bnn_seq_ctrl;
  import bnn_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pause;
  logic [15:0] inst_rdata;
  logic [10:0] inst_addr;
  logic        inst_cen;
  logic        inst_wen;
  logic [13:0] data_addr;
  logic        data_cen;
  logic        data_wen;
  logic [19:0] core_ctrl;
  logic        busy;
  logic        done;
  logic        loop_err;

  logic [15:0] imem [2048];

  int n_checks = 0;
  int n_fail   = 0;
  int run_cycles, run_bpue, run_flush;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!inst_cen) inst_rdata <= imem[inst_addr];
  end

  bnn_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pause      (pause),
    .inst_rdata (inst_rdata),
    .inst_addr  (inst_addr),
    .inst_cen   (inst_cen),
    .inst_wen   (inst_wen),
    .data_addr  (data_addr),
    .data_cen   (data_cen),
    .data_wen   (data_wen),
    .core_ctrl  (core_ctrl),
    .busy       (busy),
    .done       (done),
    .loop_err   (loop_err)
  );

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [10:0] arg);
    return {op, arg};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) imem[i] = 16'h0000;
  endtask

  // Returns in the FETCH cycle.
  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int max_cycles);
    run_cycles = 0;
    run_bpue   = 0;
    run_flush  = 0;
    while (!done && run_cycles < max_cycles) begin
      if (core_ctrl[1]) run_bpue++;
      if (dut.state == ST_FLUSH) run_flush++;
      cyc();
      run_cycles++;
    end
    chk("done_within_budget", {31'd0, done}, 32'd1);
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    pause = 1'b0;
    clear_mem();

    // Reset with a simultaneous start: reset wins.
    cyc();
    chk("rst_core_ctrl", core_ctrl, 0);
    chk("rst_data_cen", data_cen, 1);
    chk("rst_data_wen", data_wen, 1);
    chk("rst_data_addr", data_addr, 0);
    chk("rst_inst_cen", inst_cen, 1);
    chk("rst_inst_addr", inst_addr, 0);
    chk("rst_inst_wen", inst_wen, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_loop_err", loop_err, 0);
    rst   = 1'b1;
    start = 1'b0;
    cyc();
    chk("idle_busy", busy, 0);

    // Pointer loads and three incrementing weight loads.
    clear_mem();
    imem[0] = enc(5'b00001, {3'd0, 8'h10});
    imem[1] = enc(5'b00010, {3'd0, 8'h00});
    imem[2] = enc(5'b00011, 11'h001);
    imem[3] = enc(5'b00011, 11'h001);
    imem[4] = enc(5'b00011, 11'h001);
    imem[5] = enc(5'b01101, {3'd5, 3'd0, 5'd0});
    imem[6] = enc(5'b00100, {4'd5, 7'h7F});
    imem[7] = enc(5'b01110, {3'd1, 8'hAB});
    imem[8] = enc(5'b10010, 11'h000);
    pulse_start();
    chk("fetch0_addr", inst_addr, 0);
    chk("fetch0_cen", inst_cen, 0);
    chk("fetch0_busy", busy, 1);
    cyc();
    chk("fetch1_addr", inst_addr, 1);
    cyc();
    chk("fetch2_addr", inst_addr, 2);
    cyc();
    cyc();
    chk("ld0_addr", data_addr, 32'h10);
    chk("ld0_cen", data_cen, 0);
    chk("ld0_wen", data_wen, 1);
    chk("ld0_ctrl", core_ctrl, 32'h00080);
    cyc();
    chk("ld1_addr", data_addr, 32'h11);
    chk("ld1_cen", data_cen, 0);
    cyc();
    chk("ld2_addr", data_addr, 32'h12);
    chk("ld2_cen", data_cen, 0);
    cyc();
    chk("ld_after_cen", data_cen, 1);
    chk("ld_after_ctrl", core_ctrl, 0);
    run_to_done(50);
    chk("r0_final", dut.regs[0], 32'h13);
    chk("r5_mov_addi", dut.regs[5], 32'h12);
    chk("r9_ldl_high", dut.regs[9], 32'h00AB);
    chk("prog1_loop_err", loop_err, 0);

    // Nested loops: LOOP 3 { LOOP 2 { BPUE } ENDL } ENDL; HALT.
    clear_mem();
    imem[0] = enc(5'b10000, 11'd3);
    imem[1] = enc(5'b10000, 11'd2);
    imem[2] = enc(5'b01000, 11'd0);
    imem[3] = enc(5'b10001, 11'd0);
    imem[4] = enc(5'b10001, 11'd0);
    imem[5] = enc(5'b10010, 11'd0);
    pulse_start();
    run_to_done(200);
    chk("loop_bpue_pulses", run_bpue, 6);
    chk("loop_flushes", run_flush, 5);
    chk("loop_busy_cycles", run_cycles, 26);
    chk("loop_done", done, 1);
    chk("loop_err_clear", loop_err, 0);

    // Compare and taken backward jump.
    clear_mem();
    imem[0] = enc(5'b00001, {3'd3, 8'd2});
    imem[1] = enc(5'b00001, {3'd4, 8'd0});
    imem[2] = enc(5'b00101, {4'd3, 7'd5});
    imem[3] = enc(5'b00100, {4'd3, 7'd3});
    imem[4] = enc(5'b00000, 11'd0);
    imem[5] = enc(5'b00110, 11'd4);
    imem[6] = enc(5'b10010, 11'd0);
    pulse_start();
    repeat (6) cyc();
    chk("cmp_flag_set", dut.regs[2], 1);
    cyc();
    chk("jump_flush_state", {31'd0, dut.state == ST_FLUSH}, 1);
    chk("jump_target_addr", inst_addr, 1);
    chk("jump_bubble_ctrl", core_ctrl, 0);
    chk("jump_bubble_cen", data_cen, 1);
    cyc();
    chk("jump_resume_addr", inst_addr, 2);
    chk("jump_resume_run", {31'd0, dut.state == ST_RUN}, 1);
    run_to_done(50);
    chk("jump_r3_final", dut.regs[3], 8);
    chk("jump_r2_final", dut.regs[2], 0);
    chk("jump_no_second_flush", run_flush, 0);

    // Pause held for three cycles on a STORE.
    clear_mem();
    imem[0] = enc(5'b00001, {3'd1, 8'h20});
    imem[1] = enc(5'b00000, 11'd0);
    imem[2] = enc(5'b01011, 11'h200);
    imem[3] = enc(5'b00000, 11'd0);
    imem[4] = enc(5'b10010, 11'd0);
    pulse_start();
    cyc();
    cyc();
    cyc();
    pause = 1'b1;
    cyc();
    chk("pause1_data_cen", data_cen, 1);
    chk("pause1_ctrl", core_ctrl, 0);
    chk("pause1_inst_cen", inst_cen, 1);
    chk("pause1_pc_frozen", inst_addr, 3);
    cyc();
    chk("pause2_data_cen", data_cen, 1);
    chk("pause2_r1", dut.regs[1], 32'h20);
    cyc();
    chk("pause3_data_cen", data_cen, 1);
    pause = 1'b0;
    cyc();
    chk("store_cen", data_cen, 0);
    chk("store_wen", data_wen, 0);
    chk("store_addr", data_addr, 32'h20);
    chk("store_ctrl", core_ctrl, 32'h04000);
    cyc();
    chk("store_single_pulse", data_cen, 1);
    run_to_done(50);
    chk("store_r1_final", dut.regs[1], 32'h21);

    // Loop-stack overflow: LOOP_DEPTH+1 nested LOOPs.
    clear_mem();
    for (int i = 0; i < 5; i++) imem[i] = enc(5'b10000, 11'd2);
    imem[5] = enc(5'b10010, 11'd0);
    pulse_start();
    repeat (6) cyc();
    chk("ovf_done", done, 1);
    chk("ovf_loop_err", loop_err, 1);
    chk("ovf_busy", busy, 0);
    clear_mem();
    imem[0] = enc(5'b10010, 11'd0);
    pulse_start();
    chk("restart_clears_err", loop_err, 0);
    chk("restart_busy", busy, 1);
    run_to_done(20);
    chk("restart_err_stays_clear", loop_err, 0);

    // Reset in the middle of nested loops, together with a start.
    clear_mem();
    imem[0] = enc(5'b10000, 11'd3);
    imem[1] = enc(5'b10000, 11'd2);
    imem[2] = enc(5'b01000, 11'd0);
    imem[3] = enc(5'b10001, 11'd0);
    imem[4] = enc(5'b10001, 11'd0);
    imem[5] = enc(5'b10010, 11'd0);
    pulse_start();
    repeat (8) cyc();
    chk("midloop_stack_used", {31'd0, dut.u_stack.empty}, 0);
    rst   = 1'b0;
    start = 1'b1;
    cyc();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_inst_cen", inst_cen, 1);
    chk("midrst_data_cen", data_cen, 1);
    chk("midrst_ctrl", core_ctrl, 0);
    chk("midrst_stack_empty", {31'd0, dut.u_stack.empty}, 1);
    rst   = 1'b1;
    start = 1'b0;
    cyc();

    // ENDL with nothing on the stack.
    clear_mem();
    imem[0] = enc(5'b10001, 11'd0);
    imem[1] = enc(5'b10010, 11'd0);
    pulse_start();
    cyc();
    cyc();
    chk("udf_loop_err", loop_err, 1);
    chk("udf_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
